instruction_memory: RTL

Fetch-side instruction store of the IF stage, sitting directly downstream of the program counter. It is loaded byte-by-byte by the debug/loader path, assembling big-endian 32-bit words into consecutive slots. It returns the instruction addressed by the current PC combinationally, so fetch completes in the same cycle. Any slot not yet loaded reads as the HALT instruction, so a partially loaded program stops cleanly.

---
 rtl/instruction_memory_pkg.sv | 21 ++
 rtl/instruction_memory_word_assembler.sv | 58 +++++
 rtl/instruction_memory.sv | 88 ++++++++
 3 files changed

// File: rtl/instruction_memory_pkg.sv
// ----------------------------------------------------------------------------
// instruction_memory_pkg : constants and FSM state type for the instruction store
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instruction_memory_pkg;

  localparam logic [31:0] INSTR_HALT        = 32'hFFFF_FFFF;
  localparam int          DEFAULT_MEM_WORDS = 64;

  typedef enum logic [1:0] {
    STATE_BYTE0 = 2'd0,
    STATE_BYTE1 = 2'd1,
    STATE_BYTE2 = 2'd2,
    STATE_BYTE3 = 2'd3
  } asm_state_t;

endpackage

`default_nettype wire

// File: rtl/instruction_memory_word_assembler.sv
// ----------------------------------------------------------------------------
// word_assembler : packs accepted load bytes big-endian into 32-bit words
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module word_assembler
  import instruction_memory_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  asm_state_t  state;
  logic [23:0] partial;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= STATE_BYTE0;
      partial <= 24'd0;
    end else if (i_clear) begin
      state   <= STATE_BYTE0;
      partial <= 24'd0;
    end else if (i_accept) begin
      case (state)
        STATE_BYTE0: begin
          partial[23:16] <= i_data;
          state          <= STATE_BYTE1;
        end
        STATE_BYTE1: begin
          partial[15:8] <= i_data;
          state         <= STATE_BYTE2;
        end
        STATE_BYTE2: begin
          partial[7:0] <= i_data;
          state        <= STATE_BYTE3;
        end
        default: begin
          partial <= 24'd0;
          state   <= STATE_BYTE0;
        end
      endcase
    end
  end

  // The completed word is presented in the same cycle as its last byte so the
  // array captures it on the accepting edge.
  assign o_word_valid = i_accept && (state == STATE_BYTE3);
  assign o_word       = {partial, i_data};

endmodule

`default_nettype wire

// File: rtl/instruction_memory.sv
// ----------------------------------------------------------------------------
// instruction_memory : byte-loaded instruction store with combinational fetch
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int PC_SIZE   = 32,
  parameter int WORD_SIZE = 32,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_write_enable,
  input  logic [7:0]           i_data,
  input  logic [PC_SIZE-1:0]   i_pc,
  output logic [WORD_SIZE-1:0] o_instruction,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_overflow
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [WORD_SIZE-1:0] mem [MEM_WORDS];
  logic [AW:0]          wr_ptr;
  logic                 overflow;
  logic                 accept;
  logic                 word_valid;
  logic [31:0]          word;

  assign accept = i_write_enable && !o_full && !i_clear;

  word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .i_accept     (accept),
    .i_data       (i_data),
    .o_word_valid (word_valid),
    .o_word       (word)
  );

  // Array contents survive clear; visibility is governed by wr_ptr alone.
  always_ff @(posedge i_clk) begin
    if (word_valid) begin
      mem[wr_ptr[AW-1:0]] <= word;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (i_clear) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (word_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (i_write_enable && o_full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign o_full     = (wr_ptr == (AW+1)'(MEM_WORDS));
  assign o_empty    = (wr_ptr == '0);
  assign o_overflow = overflow;

  logic [AW-1:0]         rd_index;
  logic [PC_SIZE-AW-3:0] pc_high;
  logic                  rd_hit;
  logic                  unused_pc_lsbs;

  assign rd_index       = i_pc[AW+1:2];
  assign pc_high        = i_pc[PC_SIZE-1:AW+2];
  assign unused_pc_lsbs = ^i_pc[1:0];
  assign rd_hit         = (pc_high == '0) && ({1'b0, rd_index} < wr_ptr);
  assign o_instruction  = rd_hit ? mem[rd_index] : WORD_SIZE'(INSTR_HALT);

endmodule

`default_nettype wire
